// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: drives LEDs from synchronized switches in follow, blink or chase mode,
// with a debounced push-button stepping through the modes.
module led_mode_ctrl #(
   parameter int NUM_LEDS       = 4,
   parameter int TICK_DIV       = 1250000,
   parameter int DEBOUNCE_TICKS = 2,
   parameter int SLOW_TICKS     = 50,
   parameter int FAST_TICKS     = 10
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_LEDS-1:0] sw,
   input  logic                btn,
   output logic [NUM_LEDS-1:0] led,
   output logic [1:0]          mode
);
   localparam int CMAX = SLOW_TICKS > FAST_TICKS ? SLOW_TICKS : FAST_TICKS;
   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [1:0] FOLLOW = 2'd0, BLINK_SLOW = 2'd1, CHASE = 2'd3;

   logic [NUM_LEDS-1:0] sw_s1_q, sw_s2_q, sw_s1_d, sw_s2_d;
   logic                btn_s1_q, btn_s2_q, btn_s1_d, btn_s2_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [DW-1:0]       db_cnt_q, db_cnt_d;
   logic                db_q, db_d;
   logic [1:0]          mode_q, mode_d;
   logic                phase_q, phase_d;
   logic [CW-1:0]       pcnt_q, pcnt_d;
   logic [NUM_LEDS-1:0] pos_q, pos_d;
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic                tick, db_acc, adv, step;
   logic [CW-1:0]       term;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         btn_s1_q <= 1'b0;
         btn_s2_q <= 1'b0;
         presc_q  <= '0;
         db_cnt_q <= '0;
         db_q     <= 1'b0;
         mode_q   <= FOLLOW;
         phase_q  <= 1'b1;
         pcnt_q   <= '0;
         pos_q    <= NUM_LEDS'(1);
         led_q    <= '0;
      end else begin
         sw_s1_q  <= sw_s1_d;
         sw_s2_q  <= sw_s2_d;
         btn_s1_q <= btn_s1_d;
         btn_s2_q <= btn_s2_d;
         presc_q  <= presc_d;
         db_cnt_q <= db_cnt_d;
         db_q     <= db_d;
         mode_q   <= mode_d;
         phase_q  <= phase_d;
         pcnt_q   <= pcnt_d;
         pos_q    <= pos_d;
         led_q    <= led_d;
      end
   end

   // Synchronizers, prescaler and debouncer; a new level is accepted the cycle the count hits its limit
   always_comb begin
      sw_s1_d  = sw;
      sw_s2_d  = sw_s1_q;
      btn_s1_d = btn;
      btn_s2_d = btn_s1_q;
      tick     = presc_q == PW'(TICK_DIV - 1);
      presc_d  = tick ? '0 : presc_q + 1'b1;
      db_acc   = db_cnt_q == DW'(DEBOUNCE_TICKS);
      db_d     = db_acc ? btn_s2_q : db_q;
      db_cnt_d = (btn_s2_q == db_q || db_acc) ? '0 : db_cnt_q + DW'(tick);
   end

   // Mode advance outranks a coincident phase toggle or chase step
   always_comb begin
      adv     = db_acc & btn_s2_q & ~db_q;
      mode_d  = adv ? mode_q + 2'd1 : mode_q;
      term    = (mode_q == BLINK_SLOW) ? CW'(SLOW_TICKS) : CW'(FAST_TICKS);
      step    = (mode_q != FOLLOW) && (pcnt_q == term);
      pcnt_d  = (adv || step || mode_q == FOLLOW) ? '0 : pcnt_q + CW'(tick);
      phase_d = adv ? 1'b1 : (step && mode_q != CHASE) ? ~phase_q : phase_q;
      pos_d   = adv ? NUM_LEDS'(1)
              : (step && mode_q == CHASE) ? {pos_q[NUM_LEDS-2:0], pos_q[NUM_LEDS-1]} : pos_q;
   end

   always_comb begin
      led_d = (mode_q == CHASE) ? pos_q : sw_s2_q & {NUM_LEDS{phase_q | (mode_q == FOLLOW)}};
   end

   assign led  = led_q;
   assign mode = mode_q;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed scenarios for led_mode_ctrl with a short tick so every mode is reachable quickly.
module tb_led_mode_ctrl;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] sw = 4'b0000;
   logic       btn = 1'b0;
   logic [3:0] led;
   logic [1:0] mode;
   int         n_tests = 0;
   int         n_fail = 0;

   led_mode_ctrl #(
      .NUM_LEDS(4), .TICK_DIV(4), .DEBOUNCE_TICKS(2), .SLOW_TICKS(4), .FAST_TICKS(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sw(sw), .btn(btn), .led(led), .mode(mode)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds the button until the mode reaches target or the budget expires; the button is left pressed.
   task automatic press(input logic [1:0] target, output logic got);
      btn = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         if (mode === target) got = 1'b1;
      end
   endtask

   task automatic release_btn();
      btn = 1'b0;
      repeat (24) step();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      sw = 4'b1111;
      btn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_tests++;
         if (led !== 4'b0000 || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL reset[%0d]: led=%b mode=%0d, expected led=0000 mode=0", i, led, mode);
         end
      end
      reset_n = 1'b1;
      btn = 1'b0;
      sw = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         step();
         n_tests++;
         if (mode !== 2'd0 || led !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset[%0d]: led=%b mode=%0d, expected led=0000 mode=0", i, led, mode);
         end
      end
   endtask

   task automatic test_follow();
      logic [3:0] pats [2];
      logic [3:0] old;
      logic [3:0] exp;
      pats[0] = 4'b1010;
      pats[1] = 4'b0101;
      old = 4'b0000;
      for (int p = 0; p < 2; p++) begin
         sw = pats[p];
         for (int k = 1; k <= 3; k++) begin
            step();
            exp = (k < 3) ? old : pats[p];
            n_tests++;
            if (led !== exp) begin
               n_fail++;
               $display("FAIL follow p%0d edge%0d: led=%b, expected %b", p, k, led, exp);
            end
         end
         old = pats[p];
      end
   endtask

   task automatic test_debounce();
      btn = 1'b1;
      repeat (5) step();
      btn = 1'b0;
      repeat (24) step();
      n_tests++;
      if (mode !== 2'd0) begin
         n_fail++;
         $display("FAIL debounce_short: mode=%0d, expected 0", mode);
      end
      btn = 1'b1;
      repeat (3) step();
      n_tests++;
      if (mode !== 2'd0) begin
         n_fail++;
         $display("FAIL debounce_early: mode=%0d, expected 0", mode);
      end
      repeat (9) step();
      n_tests++;
      if (mode !== 2'd1) begin
         n_fail++;
         $display("FAIL debounce_accept: mode=%0d, expected 1", mode);
      end
      repeat (30) step();
      n_tests++;
      if (mode !== 2'd1) begin
         n_fail++;
         $display("FAIL debounce_hold: mode=%0d, expected 1", mode);
      end
      release_btn();
      n_tests++;
      if (mode !== 2'd1) begin
         n_fail++;
         $display("FAIL debounce_release: mode=%0d, expected 1", mode);
      end
   endtask

   task automatic test_blink_slow();
      logic [3:0] prev;
      int run, nruns, bad;
      logic first;
      sw = 4'b0110;
      repeat (40) step();
      prev = led;
      run = 1;
      nruns = 0;
      first = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (led === prev) run++;
         else begin
            n_tests++;
            if (led !== ((prev === 4'b0110) ? 4'b0000 : 4'b0110)) begin
               n_fail++;
               $display("FAIL blink_value: led=%b after %b", led, prev);
            end
            if (!first) begin
               nruns++;
               n_tests++;
               if (run != 16) begin
                  n_fail++;
                  $display("FAIL blink_period: run=%0d cycles, expected 16", run);
               end
            end
            first = 1'b0;
            run = 1;
            prev = led;
         end
      end
      n_tests++;
      if (nruns < 4) begin
         n_fail++;
         $display("FAIL blink_runs: %0d complete half-periods, expected >= 4", nruns);
      end
      sw = 4'b0000;
      repeat (3) step();
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (led !== 4'b0000) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL blink_zero_sw: %0d cycles with led!=0000, expected 0", bad);
      end
   endtask

   // Times a press so the advance to BLINK_FAST lands on the edge where phase would turn off.
   task automatic test_collision();
      logic [3:0] prev;
      logic found;
      sw = 4'b0110;
      prev = led;
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         step();
         if (prev === 4'b0110 && led === 4'b0000) found = 1'b1;
         prev = led;
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL collision_sync: no blink falling edge seen, expected one within 80 cycles");
      end else begin
         repeat (23) step();
         btn = 1'b1;
         repeat (7) step();
         n_tests++;
         if (mode !== 2'd1) begin
            n_fail++;
            $display("FAIL collision_before: mode=%0d, expected 1", mode);
         end
         step();
         n_tests++;
         if (mode !== 2'd2) begin
            n_fail++;
            $display("FAIL collision_mode: mode=%0d, expected 2", mode);
         end
         step();
         n_tests++;
         if (led !== 4'b0110) begin
            n_fail++;
            $display("FAIL collision_phase: led=%b, expected 0110", led);
         end
      end
      release_btn();
   endtask

   task automatic test_chase();
      logic got, first;
      logic [3:0] prev;
      int run, nruns;
      sw = 4'b1111;
      press(2'd3, got);
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL chase_enter: mode=%0d, expected 3", mode);
      end
      step();
      n_tests++;
      if (led !== 4'b0001) begin
         n_fail++;
         $display("FAIL chase_start: led=%b, expected 0001", led);
      end
      prev = led;
      run = 1;
      nruns = 0;
      first = 1'b1;
      for (int i = 0; i < 60; i++) begin
         sw = 4'($urandom);
         step();
         if (led === prev) run++;
         else begin
            n_tests++;
            if (led !== {prev[2:0], prev[3]}) begin
               n_fail++;
               $display("FAIL chase_order: led=%b after %b", led, prev);
            end
            if (!first) begin
               nruns++;
               n_tests++;
               if (run != 8) begin
                  n_fail++;
                  $display("FAIL chase_period: run=%0d cycles, expected 8", run);
               end
            end
            first = 1'b0;
            run = 1;
            prev = led;
         end
      end
      n_tests++;
      if (nruns < 4) begin
         n_fail++;
         $display("FAIL chase_runs: %0d complete steps, expected >= 4", nruns);
      end
      release_btn();
   endtask

   task automatic test_wrap();
      logic got;
      sw = 4'b1001;
      press(2'd0, got);
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL wrap_mode: mode=%0d, expected 0", mode);
      end
      step();
      n_tests++;
      if (led !== 4'b1001) begin
         n_fail++;
         $display("FAIL wrap_follow: led=%b, expected 1001", led);
      end
      release_btn();
   endtask

   task automatic test_reset_mid();
      logic got;
      for (int m = 1; m <= 3; m++) begin
         press(2'(m), got);
         n_tests++;
         if (!got) begin
            n_fail++;
            $display("FAIL step_mode: mode=%0d, expected %0d", mode, m);
         end
         release_btn();
      end
      repeat (5) step();
      reset_n = 1'b0;
      step();
      n_tests++;
      if (led !== 4'b0000 || mode !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid: led=%b mode=%0d, expected led=0000 mode=0", led, mode);
      end
      reset_n = 1'b1;
      repeat (3) step();
      n_tests++;
      if (mode !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid_after: mode=%0d, expected 0", mode);
      end
   endtask

   initial begin
      test_reset();
      test_follow();
      test_debounce();
      test_blink_slow();
      test_collision();
      test_chase();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
